// File: rtl/wb_uart_fifo_pkg.sv
// rtl/wb_uart_fifo_pkg.sv - shared register map, status bits and TX FSM states
// Contents:
//   REG_*   : register index taken from wishbone byte address bits [3:2]
//   ST_*    : bit positions inside the STATUS register
//   CTRL_*  : bit positions inside the CTRL register
//   tx_state_t : TX pacing FSM encoding
package wb_uart_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;

  localparam int CTRL_CLR_OVF  = 0;
  localparam int CTRL_FLUSH_TX = 1;
  localparam int CTRL_FLUSH_RX = 2;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with flush
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   push, din  : write request and data; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   flush      : discard all contents
//   dout       : head entry (valid whenever !empty)
//   full, empty, count : occupancy, count is DEPTH_LOG2+1 bits
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (cnt == DEPTH_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_fifo.sv
// rtl/wb_uart_fifo.sv - wishbone console slave buffering bytes to/from uart_bridge
// Ports:
//   i_clk, i_rst          : clock, synchronous active-low reset
//   i_wb_*                : wishbone request (cyc, stb, we, addr[3:0], data, sel)
//   o_wb_stall/ack/data   : wishbone response, ack one cycle after each request
//   o_byte_tx_data/valid  : one-cycle byte strobe to uart_bridge
//   i_byte_tx_busy        : uart_bridge transmitter active
//   i_byte_rx_data/valid  : one-cycle received byte strobe from uart_bridge
//   o_irq                 : RX FIFO not empty
module wb_uart_fifo
  import wb_uart_fifo_pkg::*;
#(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int BUSY_TIMEOUT  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic [7:0]  o_byte_tx_data,
  output logic        o_byte_tx_valid,
  input  logic        i_byte_tx_busy,
  input  logic [7:0]  i_byte_rx_data,
  input  logic        i_byte_rx_valid,
  output logic        o_irq
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  logic        req;
  logic        wr_req;
  logic        rd_req;
  logic [1:0]  reg_sel;
  logic        data_wr;
  logic        data_rd;
  logic        ctrl_wr;
  logic        clr_ovf;
  logic        flush_tx;
  logic        flush_rx;

  logic [7:0]               tx_dout;
  logic                     tx_full;
  logic                     tx_empty;
  logic [TX_DEPTH_LOG2:0]   tx_count;
  logic                     tx_pop;
  logic                     tx_ovf;

  logic [7:0]               rx_dout;
  logic                     rx_full;
  logic                     rx_empty;
  logic [RX_DEPTH_LOG2:0]   rx_count;
  logic                     rx_pop;
  logic                     rx_ovf;

  tx_state_t                tx_state;
  logic [TMR_W-1:0]         timer;
  logic [31:0]              status;
  logic [31:0]              rd_data;
  logic                     unused_bits;

  assign unused_bits = &{1'b0, i_wb_addr[1:0], i_wb_data[31:8], i_wb_sel[3:1]};

  assign o_wb_stall = 1'b0;
  assign req        = i_wb_cyc & i_wb_stb;
  assign wr_req     = req & i_wb_we;
  assign rd_req     = req & ~i_wb_we;
  assign reg_sel    = i_wb_addr[3:2];

  assign data_wr  = wr_req && (reg_sel == REG_DATA) && i_wb_sel[0];
  assign data_rd  = rd_req && (reg_sel == REG_DATA);
  assign ctrl_wr  = wr_req && (reg_sel == REG_CTRL);
  assign clr_ovf  = ctrl_wr && i_wb_data[CTRL_CLR_OVF];
  assign flush_tx = ctrl_wr && i_wb_data[CTRL_FLUSH_TX];
  assign flush_rx = ctrl_wr && i_wb_data[CTRL_FLUSH_RX];

  assign rx_pop = data_rd && !rx_empty;
  assign tx_pop = (tx_state == TX_IDLE) && !tx_empty && !i_byte_tx_busy;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (data_wr),
    .pop   (tx_pop),
    .flush (flush_tx),
    .din   (i_wb_data[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_byte_rx_valid),
    .pop   (rx_pop),
    .flush (flush_rx),
    .din   (i_byte_rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Sticky overflow flags; a new drop in the same cycle as a clear wins so
  // the event is never lost.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (clr_ovf) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
      end
      if (data_wr && tx_full && !tx_pop) begin
        tx_ovf <= 1'b1;
      end
      if (i_byte_rx_valid && rx_full && !rx_pop) begin
        rx_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_OVF]   = rx_ovf;
    status[ST_TX_OVF]   = tx_ovf;
    status[15:8]        = 8'(tx_count);
    status[23:16]       = 8'(rx_count);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   rd_data = rx_empty ? 32'h0000_0100 : {24'h0, rx_dout};
      REG_STATUS: rd_data = status;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      o_irq     <= 1'b0;
    end else begin
      o_wb_ack <= req;
      if (rd_req) begin
        o_wb_data <= rd_data;
      end
      o_irq <= !rx_empty;
    end
  end

  // TX pacing: one strobe per byte, then wait for uart_bridge to go busy and
  // idle again. The timeout covers a busy pulse that never shows up.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      tx_state        <= TX_IDLE;
      o_byte_tx_valid <= 1'b0;
      o_byte_tx_data  <= '0;
      timer           <= '0;
    end else begin
      o_byte_tx_valid <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            o_byte_tx_data  <= tx_dout;
            o_byte_tx_valid <= 1'b1;
            timer           <= '0;
            tx_state        <= TX_WAIT_BUSY;
          end
        end
        TX_WAIT_BUSY: begin
          if (i_byte_tx_busy) begin
            tx_state <= TX_WAIT_DONE;
          end else if (timer == TMR_LAST) begin
            tx_state <= TX_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        TX_WAIT_DONE: begin
          if (!i_byte_tx_busy) begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_fifo.sv
// tb/tb_wb_uart_fifo.sv - directed self-checking bench for wb_uart_fifo
module tb_wb_uart_fifo;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        irq;

  int vectors;
  int miscompares;
  int cycle;
  int busy_mode;
  int busy_cnt;
  logic busy_prev;
  logic [7:0] tx_log[$];
  int tx_time[$];

  wb_uart_fifo #(
    .TX_DEPTH_LOG2(4),
    .RX_DEPTH_LOG2(4),
    .BUSY_TIMEOUT (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wb_cyc        (cyc),
    .i_wb_stb        (stb),
    .i_wb_we         (we),
    .i_wb_addr       (addr),
    .i_wb_data       (wdata),
    .i_wb_sel        (sel),
    .o_wb_stall      (stall),
    .o_wb_ack        (ack),
    .o_wb_data       (rdata),
    .o_byte_tx_data  (tx_data),
    .o_byte_tx_valid (tx_valid),
    .i_byte_tx_busy  (busy),
    .i_byte_rx_data  (rx_data),
    .i_byte_rx_valid (rx_valid),
    .o_irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_bridge model: mode 0 = busy for 10 cycles after each strobe,
  // mode 1 = busy held high, mode 2 = busy never rises.
  initial begin
    busy      = 1'b0;
    busy_cnt  = 0;
    busy_prev = 1'b0;
    cycle     = 0;
    forever begin
      @(posedge clk);
      #2;
      cycle++;
      busy_prev = busy;
      if (tx_valid === 1'b1) begin
        tx_log.push_back(tx_data);
        tx_time.push_back(cycle);
        vectors++;
        if (busy_prev !== 1'b0) begin
          miscompares++;
          $display("FAIL tx_valid_while_busy: busy=%b required 0", busy_prev);
        end
        if (busy_mode == 0) busy_cnt = 10;
      end
      case (busy_mode)
        1: busy = 1'b1;
        2: busy = 1'b0;
        default: begin
          if (busy_cnt > 0) begin
            busy = 1'b1;
            busy_cnt--;
          end else begin
            busy = 1'b0;
          end
        end
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
    @(posedge clk);
    #1;
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL wb_write_ack addr=%h: got %b required 1", a, ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    @(posedge clk);
    #1;
    vectors++;
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL wb_read_ack addr=%h: got %b required 1", a, ack);
    end
    d = rdata;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic read_expect(input logic [3:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    bus_read(a, d);
    vectors++;
    if (d !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, d, exp);
    end
  endtask

  task automatic rx_inject(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    vectors++;
    if (tx_log.size() < n) begin
      miscompares++;
      $display("FAIL tx_pulse_timeout: got %0d pulses required %0d", tx_log.size(), n);
    end
  endtask

  task automatic check_log(input int idx, input logic [7:0] exp, input string name);
    vectors++;
    if (tx_log.size() <= idx) begin
      miscompares++;
      $display("FAIL %s: got no pulse required %h", name, exp);
    end else if (tx_log[idx] !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, tx_log[idx], exp);
    end
  endtask

  task automatic check_log_size(input int exp, input string name);
    vectors++;
    if (tx_log.size() != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d pulses required %0d", name, tx_log.size(), exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if ({ack, irq, tx_valid, rdata, tx_data} !== 43'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b irq=%b valid=%b data=%h txd=%h required all 0",
               ack, irq, tx_valid, rdata, tx_data);
    end
    rst = 1'b1;
    read_expect(4'h4, 32'h0000_0006, "reset_status");
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b required 0", irq);
    end
    tick(1);
    vectors++;
    if (ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_single_pulse: got %b required 0", ack);
    end
    check_log_size(0, "reset_no_tx_valid");
  endtask

  task automatic test_tx_order;
    int n0;
    busy_mode = 0;
    n0 = tx_log.size();
    bus_write(4'h0, 32'h0000_005A, 4'b1110);
    bus_write(4'h0, 32'h0000_0041, 4'b0001);
    bus_write(4'h0, 32'h0000_0042, 4'b0001);
    bus_write(4'h0, 32'h0000_0043, 4'b0001);
    wait_log(n0 + 3, 300);
    check_log(n0,     8'h41, "tx_order_0");
    check_log(n0 + 1, 8'h42, "tx_order_1");
    check_log(n0 + 2, 8'h43, "tx_order_2");
    if (tx_time.size() >= n0 + 2) begin
      vectors++;
      if (tx_time[n0 + 1] - tx_time[n0] < 3) begin
        miscompares++;
        $display("FAIL tx_spacing: got %0d cycles required >=3", tx_time[n0 + 1] - tx_time[n0]);
      end
    end
    tick(40);
    check_log_size(n0 + 3, "tx_sel0_gated");
    read_expect(4'h4, 32'h0000_0006, "tx_order_empty");
  endtask

  task automatic test_tx_overflow;
    int n0;
    tick(20);
    busy_mode = 1;
    tick(2);
    n0 = tx_log.size();
    for (int i = 0; i < 17; i++) begin
      bus_write(4'h0, 32'h60 + i, 4'b0001);
    end
    read_expect(4'h4, 32'h0000_1025, "tx_ovf_status");
    check_log_size(n0, "tx_held_while_busy");
    bus_write(4'h8, 32'h1, 4'b0001);
    read_expect(4'h4, 32'h0000_1005, "tx_ovf_cleared");
    busy_mode = 0;
    wait_log(n0 + 16, 600);
    tick(40);
    check_log_size(n0 + 16, "tx_17th_dropped");
    for (int i = 0; i < 16; i++) begin
      check_log(n0 + i, 8'(8'h60 + i), "tx_ovf_drain");
    end
  endtask

  task automatic test_rx_irq;
    rx_inject(8'h55);
    rx_inject(8'hAA);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_irq_set: got %b required 1", irq);
    end
    read_expect(4'h0, 32'h0000_0055, "rx_pop_0");
    read_expect(4'h0, 32'h0000_00AA, "rx_pop_1");
    tick(1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_irq_clear: got %b required 0", irq);
    end
    read_expect(4'h0, 32'h0000_0100, "rx_empty_read");
    rx_inject(8'h01);
    rx_inject(8'h02);
    bus_write(4'h8, 32'h4, 4'b0001);
    read_expect(4'h4, 32'h0000_0006, "rx_flush");
  endtask

  task automatic test_rx_full_edge;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      rx_inject(8'(8'h10 + i));
    end
    read_expect(4'h4, 32'h0010_000A, "rx_full_status");
    rx_data = 8'h99;
    rx_valid = 1'b1;
    bus_read(4'h0, d);
    rx_valid = 1'b0;
    vectors++;
    if (d !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL rx_full_pop: got %h required 00000010", d);
    end
    read_expect(4'h4, 32'h0010_000A, "rx_full_simul");
    bus_write(4'hC, 32'h0000_00FF, 4'hF);
    read_expect(4'h4, 32'h0010_000A, "reg3_write_ignored");
    read_expect(4'hC, 32'h0000_0000, "reg3_read_zero");
    rx_inject(8'hEE);
    read_expect(4'h4, 32'h0010_001A, "rx_ovf_set");
    for (int i = 1; i < 16; i++) begin
      read_expect(4'h0, 32'h10 + i, "rx_full_drain");
    end
    read_expect(4'h0, 32'h0000_0099, "rx_simul_byte_last");
    read_expect(4'h0, 32'h0000_0100, "rx_drained_empty");
    bus_write(4'h8, 32'h1, 4'b0001);
    read_expect(4'h4, 32'h0000_0006, "rx_ovf_cleared");
  endtask

  task automatic test_timeout_and_reset;
    int n0;
    int n1;
    busy_mode = 1;
    tick(3);
    n0 = tx_log.size();
    bus_write(4'h0, 32'hC1, 4'b0001);
    bus_write(4'h0, 32'hC2, 4'b0001);
    bus_write(4'h8, 32'h2, 4'b0001);
    read_expect(4'h4, 32'h0000_0006, "tx_flush");
    busy_mode = 2;
    tick(5);
    check_log_size(n0, "tx_flush_nothing_sent");
    bus_write(4'h0, 32'hA1, 4'b0001);
    bus_write(4'h0, 32'hA2, 4'b0001);
    wait_log(n0 + 2, 100);
    check_log(n0,     8'hA1, "timeout_byte_0");
    check_log(n0 + 1, 8'hA2, "timeout_byte_1");
    if (tx_time.size() >= n0 + 2) begin
      vectors++;
      if (tx_time[n0 + 1] - tx_time[n0] != 5) begin
        miscompares++;
        $display("FAIL busy_timeout_spacing: got %0d cycles required 5",
                 tx_time[n0 + 1] - tx_time[n0]);
      end
    end
    tick(10);
    busy_mode = 0;
    tick(2);
    n1 = tx_log.size();
    bus_write(4'h0, 32'hB1, 4'b0001);
    bus_write(4'h0, 32'hB2, 4'b0001);
    bus_write(4'h0, 32'hB3, 4'b0001);
    wait_log(n1 + 1, 100);
    check_log(n1, 8'hB1, "pre_reset_byte");
    tick(3);
    rst = 1'b0;
    tick(1);
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midop_valid: got %b required 0", tx_valid);
    end
    rst = 1'b1;
    read_expect(4'h4, 32'h0000_0006, "reset_midop_empty");
    tick(40);
    check_log_size(n1 + 1, "reset_midop_discard");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    busy_mode   = 0;
    rst         = 1'b0;
    cyc         = 1'b0;
    stb         = 1'b0;
    we          = 1'b0;
    addr        = 4'h0;
    wdata       = 32'h0;
    sel         = 4'h0;
    rx_data     = 8'h0;
    rx_valid    = 1'b0;
    #1;
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx_irq();
    test_rx_full_edge();
    test_timeout_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
